// File: rtl/dmem_lsu_pkg.sv
// Shared encodings for the data-RAM load/store unit: access sizes, FSM states
// and the alignment rule that decides whether a request may touch the RAM.
package dmem_lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Size 2'b11 falls into the word rule along with SIZE_WORD.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = offset[0];
      default:   mis = (offset != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// CPU-side request/response bundle of the load/store unit.
interface dmem_lsu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 10
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [BUS_WIDTH+1:0]  req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_err;
  logic [DATA_WIDTH-1:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/dmem_lsu_align.sv
// Little-endian byte-lane logic: extracts and extends load data, and merges
// sub-word store data into a previously read RAM word.
module lsu_align
  import dmem_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  input  logic [1:0]            offset,
  input  logic [DATA_WIDTH-1:0] rd_word,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] merge_word,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic [DATA_WIDTH-1:0] st_word
);

  logic [4:0]  bit_off;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign bit_off  = {offset, 3'b000};
  assign byte_sel = rd_word[bit_off +: 8];
  assign half_sel = offset[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (size)
      SIZE_BYTE: ld_data = {{(DATA_WIDTH-8){~is_unsigned & byte_sel[7]}}, byte_sel};
      SIZE_HALF: ld_data = {{(DATA_WIDTH-16){~is_unsigned & half_sel[15]}}, half_sel};
      default:   ld_data = rd_word;
    endcase
  end

  always_comb begin
    st_word = merge_word;
    case (size)
      SIZE_BYTE: st_word[bit_off +: 8] = wdata[7:0];
      SIZE_HALF: begin
        if (offset[1]) st_word[31:16] = wdata[15:0];
        else           st_word[15:0]  = wdata[15:0];
      end
      default:   st_word = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator for the word-wide data RAM: one CPU request at a time,
// sub-word stores done as read-modify-write, single-cycle response pulse.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_lsu_if.slave             cpu,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [BUS_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [BUS_WIDTH+1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] merge_q, merge_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

  logic [DATA_WIDTH-1:0] ld_data;
  logic [DATA_WIDTH-1:0] st_word;
  logic                  is_word;

  assign is_word = size_q[1];

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .offset      (addr_q[1:0]),
    .rd_word     (mem_rdata),
    .wdata       (wdata_q),
    .merge_word  (merge_q),
    .ld_data     (ld_data),
    .st_word     (st_word)
  );

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    merge_d      = merge_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      IDLE: begin
        if (cpu.req_valid) begin
          we_d    = cpu.req_we;
          size_d  = cpu.req_size;
          uns_d   = cpu.req_unsigned;
          addr_d  = cpu.req_addr;
          wdata_d = cpu.req_wdata;
          if (is_misaligned(cpu.req_size, cpu.req_addr[1:0])) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!we_q) begin
          resp_rdata_d = ld_data;
          state_d      = RESP;
          resp_valid_d = 1'b1;
        end else if (is_word) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
        end else begin
          merge_d = mem_rdata;
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      default: begin
        state_d      = IDLE;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      merge_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      merge_q      <= merge_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // RAM strobes come straight from state so an async reset drops them at once.
  assign mem_re    = (state_q == ACCESS);
  assign mem_we    = (state_q == WRITE) || ((state_q == ACCESS) && we_q && is_word);
  assign mem_addr  = addr_q[BUS_WIDTH+1:2];
  assign mem_wdata = mem_we ? st_word : '0;

  assign cpu.req_ready  = (state_q == IDLE);
  assign cpu.resp_valid = resp_valid_q;
  assign cpu.resp_err   = resp_err_q;
  assign cpu.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a RAM model and a transaction-level
// reference that predicts RAM strobes and responses cycle by cycle.
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

  localparam int DW = 32;
  localparam int BW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_lsu_if #(.DATA_WIDTH(DW), .BUS_WIDTH(BW)) cpu ();

  logic          mem_re, mem_we;
  logic [BW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  dmem_lsu #(.DATA_WIDTH(DW), .BUS_WIDTH(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu       (cpu),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // RAM: combinational read, write on the clock edge, plus bench-side preload.
  logic [DW-1:0] ram [0:1023];
  logic          clr_ram, poke_en;
  logic [BW-1:0] poke_a;
  logic [DW-1:0] poke_d;
  assign mem_rdata = mem_re ? ram[mem_addr] : '0;
  always @(posedge clk) begin
    if (clr_ram) begin
      for (int i = 0; i < 1024; i++) ram[i] <= '0;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end else if (poke_en) begin
      ram[poke_a] <= poke_d;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state.
  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  logic [31:0] ref_ram [0:1023];
  bit          exp_re [int];
  bit          exp_we [int];
  logic [31:0] exp_wd [int];
  logic [9:0]  exp_wa [int];
  resp_t       rq [$];

  int          checks = 0;
  int          failures = 0;
  bit          model_on = 1'b0;
  int          resp_seen = 0;
  int          last_resp_cyc = 0;
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                           input logic [1:0] off, input logic [31:0] w);
    logic [31:0] v;
    if (size == 2'b00) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 2'b01) begin
      v = (w >> (16 * off[1])) & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // Predict everything a request accepted on edge a will cause.
  task automatic model_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [11:0] addr, input logic [31:0] wd, input int a);
    logic [1:0]  off;
    logic [9:0]  wa;
    logic        mis;
    logic [31:0] nw;
    int          sh;
    resp_t       r;
    off = addr[1:0];
    wa  = addr[11:2];
    mis = (size == 2'b01 && off[0]) || (size[1] && off != 2'b00);
    r.err = 1'b0;
    r.rdata = '0;
    if (mis) begin
      r.due = a;
      r.err = 1'b1;
    end else if (!we) begin
      exp_re[a] = 1'b1;
      r.due = a + 1;
      r.rdata = ref_load(size, uns, off, ref_ram[wa]);
    end else if (size[1]) begin
      exp_re[a] = 1'b1;
      exp_we[a] = 1'b1;
      exp_wd[a] = wd;
      exp_wa[a] = wa;
      ref_ram[wa] = wd;
      r.due = a + 1;
    end else begin
      nw = ref_ram[wa];
      if (size == 2'b00) begin
        sh = 8 * off;
        nw = (nw & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
      end else begin
        sh = 16 * off[1];
        nw = (nw & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
      end
      exp_re[a] = 1'b1;
      exp_we[a + 1] = 1'b1;
      exp_wd[a + 1] = nw;
      exp_wa[a + 1] = wa;
      ref_ram[wa] = nw;
      r.due = a + 2;
    end
    rq.push_back(r);
  endtask

  // Per-cycle compare of RAM strobes and response against the model.
  always @(negedge clk) begin
    if (model_on && !rst) begin
      bit e_re, e_we;
      e_re = exp_re.exists(cyc) ? exp_re[cyc] : 1'b0;
      e_we = exp_we.exists(cyc) ? exp_we[cyc] : 1'b0;
      check("mem_re", mem_re, e_re);
      check("mem_we", mem_we, e_we);
      if (e_we) begin
        check("mem_wdata", mem_wdata, exp_wd[cyc]);
        check("mem_addr", mem_addr, exp_wa[cyc]);
      end else begin
        check("mem_wdata_idle", mem_wdata, 32'h0);
      end
      if (rq.size() != 0 && rq[0].due == cyc) begin
        check("resp_valid", cpu.resp_valid, 1'b1);
        check("resp_err", cpu.resp_err, rq[0].err);
        check("resp_rdata", cpu.resp_rdata, rq[0].rdata);
        last_rdata    = cpu.resp_rdata;
        last_err      = cpu.resp_err;
        last_resp_cyc = cyc;
        resp_seen++;
        void'(rq.pop_front());
      end else begin
        check("resp_valid_quiet", cpu.resp_valid, 1'b0);
      end
    end
  end

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    poke_a = a;
    poke_d = d;
    poke_en = 1'b1;
    @(negedge clk);
    poke_en = 1'b0;
    ref_ram[a] = d;
  endtask

  // Called at a negedge; returns the accepting edge number.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [11:0] addr, input logic [31:0] wd,
                       input bit hold, output int a);
    int n;
    cpu.req_valid    = 1'b1;
    cpu.req_we       = we;
    cpu.req_size     = size;
    cpu.req_unsigned = uns;
    cpu.req_addr     = addr;
    cpu.req_wdata    = wd;
    n = 0;
    while (!cpu.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cpu.req_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=ready_low required=ready_high");
    end
    a = cyc + 1;
    model_req(we, size, uns, addr, wd, a);
    @(negedge clk);
    if (!hold) cpu.req_valid = 1'b0;
    cpu.req_addr  = ~addr;
    cpu.req_wdata = ~wd;
    cpu.req_we    = ~we;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (rq.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL resp_timeout actual=%0d_pending required=0", rq.size());
      rq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int a, a1, a2, a3, seen0, mism;
    rst = 1'b1;
    clr_ram = 1'b1;
    poke_en = 1'b0;
    poke_a = '0;
    poke_d = '0;
    cpu.req_valid = 1'b0;
    cpu.req_we = 1'b0;
    cpu.req_size = 2'b00;
    cpu.req_unsigned = 1'b0;
    cpu.req_addr = '0;
    cpu.req_wdata = '0;
    last_rdata = '0;
    last_err = 1'b0;
    for (int i = 0; i < 1024; i++) ref_ram[i] = '0;
    @(negedge clk);
    @(negedge clk);
    clr_ram = 1'b0;
    check("rst_req_ready", cpu.req_ready, 1'b1);
    check("rst_resp_valid", cpu.resp_valid, 1'b0);
    check("rst_resp_err", cpu.resp_err, 1'b0);
    check("rst_resp_rdata", cpu.resp_rdata, 32'h0);
    check("rst_mem_re", mem_re, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    rst = 1'b0;
    model_on = 1'b1;
    @(negedge clk);

    // Word store then word load.
    issue(1'b1, SIZE_WORD, 1'b0, 12'h010, 32'hDEADBEEF, 1'b0, a);
    wait_idle();
    issue(1'b0, SIZE_WORD, 1'b0, 12'h010, 32'h0, 1'b0, a);
    wait_idle();
    check("lit_word_load", last_rdata, 32'hDEADBEEF);
    check("lit_word_load_err", last_err, 1'b0);
    check("lat_load", last_resp_cyc + 1 - a, 2);

    // Byte store read-modify-write.
    poke(10'd4, 32'h11223344);
    issue(1'b1, SIZE_BYTE, 1'b0, 12'h011, 32'h5555_55AA, 1'b0, a);
    wait_idle();
    check("lit_byte_store", ram[4], 32'h1122AA44);
    check("lat_subword_store", last_resp_cyc + 1 - a, 3);

    // Half store in the upper lane.
    poke(10'd6, 32'h11223344);
    issue(1'b1, SIZE_HALF, 1'b0, 12'h01A, 32'h1234BEEF, 1'b0, a);
    wait_idle();
    check("lit_half_store", ram[6], 32'hBEEF3344);

    // Extension cases.
    poke(10'd4, 32'h8000FF80);
    issue(1'b0, SIZE_BYTE, 1'b0, 12'h010, 32'h0, 1'b0, a);
    wait_idle();
    check("lit_lb_signed", last_rdata, 32'hFFFFFF80);
    issue(1'b0, SIZE_BYTE, 1'b1, 12'h010, 32'h0, 1'b0, a);
    wait_idle();
    check("lit_lb_unsigned", last_rdata, 32'h00000080);
    issue(1'b0, SIZE_HALF, 1'b0, 12'h012, 32'h0, 1'b0, a);
    wait_idle();
    check("lit_lh_signed", last_rdata, 32'hFFFF8000);
    issue(1'b0, SIZE_HALF, 1'b1, 12'h012, 32'h0, 1'b0, a);
    wait_idle();
    issue(1'b0, SIZE_BYTE, 1'b0, 12'h011, 32'h0, 1'b0, a);
    wait_idle();
    issue(1'b0, 2'b11, 1'b0, 12'h010, 32'h0, 1'b0, a);
    wait_idle();
    check("lit_size11_word", last_rdata, 32'h8000FF80);

    // Top of the address space.
    poke(10'd1023, 32'hA5C3_0000);
    issue(1'b0, SIZE_BYTE, 1'b1, 12'hFFF, 32'h0, 1'b0, a);
    wait_idle();
    check("lit_top_byte", last_rdata, 32'h000000A5);

    // Misaligned requests.
    issue(1'b0, SIZE_HALF, 1'b0, 12'h013, 32'h0, 1'b0, a);
    wait_idle();
    check("lit_mis_half_err", last_err, 1'b1);
    check("lit_mis_half_rdata", last_rdata, 32'h0);
    check("lat_misaligned", last_resp_cyc + 1 - a, 1);
    issue(1'b1, SIZE_WORD, 1'b0, 12'h016, 32'hCAFEF00D, 1'b0, a);
    wait_idle();
    check("lit_mis_word_err", last_err, 1'b1);
    check("lit_mis_word_ram", ram[5], 32'h0);

    // Reset in the WRITE cycle of a byte store to word 5.
    model_on = 1'b0;
    seen0 = resp_seen;
    cpu.req_valid = 1'b1;
    cpu.req_we = 1'b1;
    cpu.req_size = SIZE_BYTE;
    cpu.req_unsigned = 1'b0;
    cpu.req_addr = 12'h015;
    cpu.req_wdata = 32'h77;
    @(negedge clk);
    cpu.req_valid = 1'b0;
    @(negedge clk);
    check("rstw_in_write", mem_we, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rstw_mem_we_drop", mem_we, 1'b0);
    check("rstw_mem_re_drop", mem_re, 1'b0);
    @(negedge clk);
    check("rstw_ram5", ram[5], 32'h0);
    rst = 1'b0;
    check("rstw_ready", cpu.req_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("rstw_no_resp", cpu.resp_valid, 1'b0);
      @(negedge clk);
    end
    check("rstw_ram5_after", ram[5], 32'h0);
    model_on = 1'b1;

    // Three loads with req_valid held high.
    seen0 = resp_seen;
    issue(1'b0, SIZE_BYTE, 1'b0, 12'h010, 32'h0, 1'b1, a1);
    issue(1'b0, SIZE_BYTE, 1'b1, 12'h013, 32'h0, 1'b1, a2);
    issue(1'b0, SIZE_HALF, 1'b0, 12'h018, 32'h0, 1'b0, a3);
    wait_idle();
    check("b2b_gap1", a2 - a1, 3);
    check("b2b_gap2", a3 - a2, 3);
    check("b2b_count", resp_seen - seen0, 3);

    repeat (3) @(negedge clk);
    mism = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== ref_ram[i]) mism++;
    check("ram_image", mism, 0);
    check("pending_resp", rq.size(), 0);
    model_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store initiator for the word-wide data RAM: the requester side of its re/we/addr/wdata/rdata port.
- Accepts one byte-addressed CPU request at a time over a valid/ready handshake.
- Performs byte/halfword/word loads with sign or zero extension.
- Performs sub-word stores as read-modify-write.
- Returns a single-cycle response pulse carrying load data or a misalignment error.

Parameters:
- DATA_WIDTH, 32, RAM word width; fixed at 32 because the byte-lane logic assumes 4 lanes.
- BUS_WIDTH, 10, RAM word-address width; the CPU byte address is BUS_WIDTH+2 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  BUS_WIDTH+2  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  misaligned request; qualified by resp_valid.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- mem_re  out  1  RAM read enable.
- mem_we  out  1  RAM write enable; the RAM writes on the clk edge.
- mem_addr  out  BUS_WIDTH  RAM word address = latched req_addr[BUS_WIDTH+1:2].
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_rdata  in  DATA_WIDTH  RAM read data; combinational from mem_addr when mem_re=1.

Behaviour:
- States: IDLE, ACCESS, WRITE, RESP.
- Reset values (async, take effect immediately):
  - state = IDLE.
  - resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - Request latches = 0.
  - mem_re = 0 and mem_we = 0, because both are decoded from state.
- IDLE:
  - req_ready = 1.
  - On req_valid at an edge, latch we/size/unsigned/addr/wdata.
  - Misaligned request (half with addr[0]=1; word with addr[1:0]!=0): go to RESP with err=1. The RAM is not touched.
  - Otherwise go to ACCESS.
- ACCESS:
  - mem_re = 1; mem_addr = latched word address.
  - Load: extract the lane (byte lane = addr[1:0], half lane = addr[1], little-endian), extend, register into resp_rdata, go to RESP.
  - Word store: mem_we = 1, mem_wdata = latched wdata, go to RESP.
  - Sub-word store: register mem_rdata into a merge word, go to WRITE.
- WRITE:
  - mem_we = 1, mem_re = 0.
  - mem_wdata = merge word with the addressed lane replaced by req_wdata[7:0] (byte) or req_wdata[15:0] (half).
  - Go to RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle.
  - resp_err and resp_rdata hold this request's values.
  - Go to IDLE. There is no response back-pressure.
- Outputs outside RESP:
  - resp_err and resp_rdata clear to 0 on the transition to IDLE.
  - mem_we and mem_re are 0 in every state except as listed above.
  - mem_wdata is 0 when mem_we = 0.
- Latency, counted in cycles after the accepting edge until resp_valid is high:
  - Misaligned: 1 cycle.
  - Load or word store: 2 cycles.
  - Sub-word store: 3 cycles.
- Throughput: back-to-back requests are accepted one cycle after resp_valid, since req_ready is high in the IDLE cycle.
- Inputs are ignored outside IDLE; req_* may change freely after acceptance.
- Reset mid-operation: a reset asserted during WRITE or ACCESS drops mem_we immediately. No partial write is committed after reset, and no response is produced.
- Wrap-around: the maximum byte address maps to word 2**BUS_WIDTH-1. There is no address overflow because widths match exactly.

Decomposition:
- Package dmem_lsu_pkg holds:
  - Size encodings: SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b10.
  - State encodings: IDLE, ACCESS, WRITE, RESP as a 2-bit localparam set.
  - LANES = 4.
- One sub-module, lsu_align, is purely combinational and has two functions:
  - Load lane extract plus sign/zero extension.
  - Store lane merge.
- The FSM, latches and the memory-side decode stay in dmem_lsu.

Test Plan:
- Word store 0xDEADBEEF at byte addr 0x010, then word load of 0x010 → resp_rdata = 0xDEADBEEF, err = 0. Load resp_valid arrives 2 cycles after acceptance.
- With RAM word 4 = 0x11223344: byte store 0xAA at addr 0x011 → RAM word 4 = 0x1122AA44. mem_re is seen in ACCESS, mem_we in WRITE, and resp_valid 3 cycles after acceptance.
- With RAM word 4 = 0x8000FF80:
  - Signed byte load of 0x010 → 0xFFFFFF80; unsigned → 0x00000080.
  - Signed half load of 0x012 → 0xFFFF8000.
- Half load at 0x013 and word store at 0x016 → each gives resp_err = 1, resp_rdata = 0, resp_valid 1 cycle after acceptance. mem_re and mem_we stay 0 throughout, and RAM is unchanged.
- Assert rst during WRITE of a byte store to word 5 (initially 0x00000000) → mem_we falls immediately, RAM word 5 stays 0, resp_valid never pulses, and req_ready = 1 after reset release.
- req_valid held high for 3 consecutive loads → each is accepted only in IDLE. Exactly 3 resp_valid pulses occur, the first accepting edge is followed by the next acceptance 3 cycles later, and no request is duplicated or dropped.
